// File: rtl/spi_target.sv
`timescale 1ns/1ps
// spi_target_fifo: 8-bit wide synchronous FIFO, show-ahead head output.
//   push_i/data_i : write side; a push while full is dropped unless a pop
//                   happens in the same cycle (count then stays unchanged)
//   pop_i         : read side; a pop while empty is ignored
//   full_o/empty_o/head_o/count_o : status, head of queue, occupancy
module spi_target_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [7:0]    head_o,
  output logic [AW:0]   count_o
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop_i & (cnt_q != '0);
    do_push = push_i & ((cnt_q != FULL_CNT) | do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = data_i;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// spi_target: SPI target (slave) with TX/RX byte FIFOs, all four SPI modes,
// MSB/LSB first. SPI pins are oversampled by clk.
//   sclk_i/cs_n_i/mosi_i      : async SPI inputs (2-flop synchronized)
//   miso_o/miso_oe_o          : serial out and its enable (enable == busy_o)
//   cpol_i/cpha_i/spi_shift_direct_i : mode, 1 = LSB first
//   tx_fifo_*                 : bus push side of the TX FIFO
//   rx_fifo_*                 : bus pop side of the RX FIFO (show-ahead)
//   *_water_mark_i/*_fifo_mark_o : registered level flags
//   busy_o/byte_done_o/rx_overflow_o/tx_underrun_o : status, pulses 1 clk
//
// Handshake: tx_fifo_write_i and rx_fifo_read_i are single-cycle strobes
// sampled on clk; each asserted cycle is one push/pop. A push while full
// or a pop while empty is silently ignored; rx_fifo_data_o always shows
// the current RX head.
module spi_target #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_i,
  input  logic       cs_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic       spi_shift_direct_i,
  input  logic       tx_fifo_write_i,
  input  logic [7:0] tx_fifo_data_i,
  output logic       tx_fifo_full_o,
  input  logic       rx_fifo_read_i,
  output logic [7:0] rx_fifo_data_o,
  output logic       rx_fifo_empty_o,
  input  logic [2:0] tx_water_mark_i,
  input  logic [2:0] rx_water_mark_i,
  output logic       tx_fifo_mark_o,
  output logic       rx_fifo_mark_o,
  output logic       busy_o,
  output logic       byte_done_o,
  output logic       rx_overflow_o,
  output logic       tx_underrun_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [2:0]  sclk_s_q, sclk_s_d;
  logic [1:0]  cs_s_q, cs_s_d, mosi_s_q, mosi_s_d, sync_vld_q, sync_vld_d;
  logic        armed_q, armed_d;
  logic [7:0]  rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [2:0]  rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic        rx_push_q, rx_push_d, byte_done_q, byte_done_d;
  logic        rx_ovf_q, rx_ovf_d, tx_unf_q, tx_unf_d;
  logic        tx_mark_q, tx_mark_d, rx_mark_q, rx_mark_d;

  logic        sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic        sample_edge, drive_edge, cs_low, mosi_s, tx_load;
  logic        tx_empty, rx_full;
  logic [7:0]  tx_head;
  logic [AW:0] tx_count, rx_count;

  always_comb begin
    sclk_rise   = sclk_s_q[1] & ~sclk_s_q[2];
    sclk_fall   = ~sclk_s_q[1] & sclk_s_q[2];
    lead_edge   = cpol_i ? sclk_fall : sclk_rise;
    trail_edge  = cpol_i ? sclk_rise : sclk_fall;
    sample_edge = cpha_i ? trail_edge : lead_edge;
    drive_edge  = cpha_i ? lead_edge : trail_edge;
    cs_low      = ~cs_s_q[1];
    mosi_s      = mosi_s_q[1];
  end

  always_comb begin
    sclk_s_d    = {sclk_s_q[1:0], sclk_i};
    cs_s_d      = {cs_s_q[0], cs_n_i};
    mosi_s_d    = {mosi_s_q[0], mosi_i};
    // The synchronizers come out of reset holding preset values; only
    // once real samples have reached the second stage can a high cs_n
    // re-arm the FSM. This keeps a transfer interrupted by reset from
    // resuming until the controller opens a fresh frame.
    sync_vld_d  = {sync_vld_q[0], 1'b1};
    armed_d     = armed_q | (sync_vld_q[1] & cs_s_q[1]);
    state_d     = state_q;
    rx_shift_d  = rx_shift_q;
    rx_cnt_d    = rx_cnt_q;
    tx_shift_d  = tx_shift_q;
    tx_cnt_d    = tx_cnt_q;
    rx_push_d   = 1'b0;
    byte_done_d = rx_push_q;
    rx_ovf_d    = rx_push_q & rx_full;
    tx_unf_d    = 1'b0;
    tx_load     = 1'b0;
    tx_mark_d   = 3'(tx_count) < tx_water_mark_i;
    rx_mark_d   = 3'(rx_count) > rx_water_mark_i;

    case (state_q)
      IDLE: begin
        if (armed_q && cs_low) begin
          state_d = ACTIVE;
          // cpha=0 must present bit 0 before the first SCLK edge.
          if (!cpha_i) tx_load = 1'b1;
        end
      end
      ACTIVE: begin
        if (!cs_low) begin
          state_d    = IDLE;
          rx_shift_d = '0;
          rx_cnt_d   = '0;
          tx_cnt_d   = '0;
        end else begin
          if (sample_edge) begin
            rx_shift_d = spi_shift_direct_i ? {mosi_s, rx_shift_q[7:1]}
                                            : {rx_shift_q[6:0], mosi_s};
            rx_cnt_d   = rx_cnt_q + 3'd1;
            if (rx_cnt_q == 3'd7) rx_push_d = 1'b1;
          end
          if (drive_edge) begin
            tx_cnt_d = tx_cnt_q + 3'd1;
            if (cpha_i ? (tx_cnt_q == 3'd0) : (tx_cnt_q == 3'd7)) begin
              tx_load = 1'b1;
            end else begin
              tx_shift_d = spi_shift_direct_i ? {1'b0, tx_shift_q[7:1]}
                                              : {tx_shift_q[6:0], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (tx_load) begin
      tx_shift_d = tx_empty ? 8'hFF : tx_head;
      tx_unf_d   = tx_empty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sclk_s_q    <= 3'b000;
      cs_s_q      <= 2'b11;
      mosi_s_q    <= 2'b00;
      sync_vld_q  <= 2'b00;
      armed_q     <= 1'b0;
      rx_shift_q  <= '0;
      rx_cnt_q    <= '0;
      tx_shift_q  <= '0;
      tx_cnt_q    <= '0;
      rx_push_q   <= 1'b0;
      byte_done_q <= 1'b0;
      rx_ovf_q    <= 1'b0;
      tx_unf_q    <= 1'b0;
      tx_mark_q   <= 1'b0;
      rx_mark_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_s_q    <= sclk_s_d;
      cs_s_q      <= cs_s_d;
      mosi_s_q    <= mosi_s_d;
      sync_vld_q  <= sync_vld_d;
      armed_q     <= armed_d;
      rx_shift_q  <= rx_shift_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_shift_q  <= tx_shift_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_push_q   <= rx_push_d;
      byte_done_q <= byte_done_d;
      rx_ovf_q    <= rx_ovf_d;
      tx_unf_q    <= tx_unf_d;
      tx_mark_q   <= tx_mark_d;
      rx_mark_q   <= rx_mark_d;
    end
  end

  spi_target_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (tx_fifo_write_i),
    .data_i (tx_fifo_data_i),
    .pop_i  (tx_load),
    .full_o (tx_fifo_full_o),
    .empty_o(tx_empty),
    .head_o (tx_head),
    .count_o(tx_count)
  );

  spi_target_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (rx_push_q),
    .data_i (rx_shift_q),
    .pop_i  (rx_fifo_read_i),
    .full_o (rx_full),
    .empty_o(rx_fifo_empty_o),
    .head_o (rx_fifo_data_o),
    .count_o(rx_count)
  );

  assign busy_o        = (state_q == ACTIVE);
  assign miso_oe_o     = busy_o;
  assign miso_o        = busy_o & (spi_shift_direct_i ? tx_shift_q[0] : tx_shift_q[7]);
  assign byte_done_o   = byte_done_q;
  assign rx_overflow_o = rx_ovf_q;
  assign tx_underrun_o = tx_unf_q;
  assign tx_fifo_mark_o = tx_mark_q;
  assign rx_fifo_mark_o = rx_mark_q;
endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, 8, entries in each of the TX and RX FIFOs (power of two, >=2).
REQ-002 SHALL have port clk  input  1  system clock; all state is on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port sclk_i  input  1  SPI clock from the external controller (asynchronous).
REQ-005 SHALL have port cs_n_i  input  1  chip select, active low (asynchronous).
REQ-006 SHALL have port mosi_i  input  1  serial data from the controller (asynchronous).
REQ-007 SHALL have ports miso_o / miso_oe_o  output  1 / 1  serial data to the controller / its output enable.
REQ-008 SHALL have ports cpol_i, cpha_i, spi_shift_direct_i  input  1 each  mode bits; spi_shift_direct_i=1 means LSB first.
REQ-009 SHALL have ports tx_fifo_write_i  input  1, tx_fifo_data_i  input  8, tx_fifo_full_o  output  1  bus-side TX push.
REQ-010 SHALL have ports rx_fifo_read_i  input  1, rx_fifo_data_o  output  8 (head, show-ahead), rx_fifo_empty_o  output  1  bus-side RX pop.
REQ-011 SHALL have ports tx_water_mark_i / rx_water_mark_i  input  3 each, tx_fifo_mark_o / rx_fifo_mark_o  output  1 each.
REQ-012 SHALL have status outputs busy_o, byte_done_o, rx_overflow_o, tx_underrun_o  output  1 each.

Function
REQ-013 SHALL pass sclk_i, cs_n_i and mosi_i through 2-flop synchronizers (reset values 0, 1, 0); a third sclk flop drives edge detection.
REQ-014 SHALL define the leading edge as rising when cpol_i=0 and falling when cpol_i=1; the trailing edge is the opposite.
REQ-015 SHALL define the sample edge as leading (cpha_i=0) or trailing (cpha_i=1), and the drive edge as the other one.
REQ-016 SHALL implement an FSM with states IDLE and ACTIVE: IDLE->ACTIVE on synchronized cs_n low, and ACTIVE->IDLE on synchronized cs_n high.
REQ-017 SHALL ignore SCLK edges in IDLE; busy_o=1 exactly in ACTIVE, and miso_oe_o equals busy_o.
REQ-018 SHALL, on each sample edge, shift synchronized mosi into the 8-bit rx shift register and increment a 3-bit rx counter.
REQ-019 SHALL shift MSB first as {rx[6:0],mosi}, or LSB first as {mosi,rx[7:1]}.
REQ-020 SHALL, on the sample edge where the rx counter is 7, push the assembled byte into the RX FIFO on the next clk and pulse byte_done_o for 1 cycle.
REQ-021 SHALL, if the RX FIFO is full at that push, drop the byte and pulse rx_overflow_o for 1 cycle.
REQ-022 SHALL drive miso_o from tx shift bit [7] (MSB first) or bit [0] (LSB first) while ACTIVE, and drive 0 while IDLE.
REQ-023 SHALL use a 3-bit tx counter that increments on each drive edge.
REQ-024 SHALL, for cpha_i=0, load the tx shift register on the IDLE->ACTIVE transition and on the drive edge where the tx counter is 7; other drive edges shift by 1 (zero fill).
REQ-025 SHALL, for cpha_i=1, load the tx shift register on the drive edge where the tx counter is 0; other drive edges shift.
REQ-026 SHALL, on a load, pop the TX FIFO head; if the TX FIFO is empty, load 8'hFF and pulse tx_underrun_o for 1 cycle.
REQ-027 SHALL, on cs_n deassertion mid-byte, discard the partial rx byte and clear both counters; a popped tx byte is not restored.
REQ-028 SHALL accept a FIFO write when full or a read when empty with no effect; a simultaneous push and pop keeps the count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-029 SHALL register tx_fifo_mark_o = (tx count[2:0] < tx_water_mark_i) and rx_fifo_mark_o = (rx count[2:0] > rx_water_mark_i) every clk.
REQ-030 SHALL require SCLK half-period >=4 clk periods; cpol_i, cpha_i and spi_shift_direct_i change only while busy_o=0.

Reset
REQ-031 SHALL, when rst_n is low, asynchronously force: state IDLE, shift registers and counters 0, FIFOs empty (rx_fifo_empty_o=1, tx_fifo_full_o=0, rx_fifo_data_o=0), miso_o=0, miso_oe_o=0, marks 0, and all status pulses 0.
REQ-032 SHALL, if reset asserts mid-transfer, lose all FIFO and shift contents; after release, ignore SCLK until the next cs_n high->low.

Verification
REQ-033 SHALL cover: mode 0, MSB first, TX FIFO={8'hA5}, controller sends 8'h3C -> MISO bits 1,0,1,0,0,1,0,1; RX head=8'h3C; byte_done_o pulses once.
REQ-034 SHALL cover: mode 3, LSB first, TX={8'h01,8'h80}, 2-byte burst with mosi 8'hF0,8'h0F -> MISO 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1; RX=8'hF0,8'h0F.
REQ-035 SHALL cover: empty TX FIFO, 1-byte transfer -> MISO all 1s, tx_underrun_o pulses once, and RX receives the byte.
REQ-036 SHALL cover: RX FIFO holding 8 bytes, a 9th byte received -> rx_overflow_o pulses, count stays 8, and the head is unchanged.
REQ-037 SHALL cover: cs_n raised after 5 bits, then a new 8-bit frame 8'h55 -> RX holds only 8'h55 and busy_o=0 between frames.
REQ-038 SHALL cover: rx_water_mark_i=2 with 3 bytes received -> rx_fifo_mark_o=1; after 2 pops it returns to 0; rst_n pulsed mid-byte -> all outputs at reset values.
